// File: rtl/mul_pkg.sv
// Shared encodings and defaults for the multiplier result stage.
package mul_pkg;
  localparam logic [1:0] MUL_OP_MUL    = 2'b00;  // low half of the product
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;  // high half, signed x signed
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;  // high half, signed x unsigned
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;  // high half, unsigned x unsigned

  localparam int MUL_TAG_W      = 5;
  localparam int MUL_FIFO_DEPTH = 2;
endpackage

// File: rtl/mul_out_fifo.sv
// Two-entry register FIFO with valid/ready on both sides and a synchronous flush.
// in_ready depends only on the registered count, so there is no comb path
// from out_ready back to in_ready.
module mul_out_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              push, pop;

  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state: flush wins over push/pop; otherwise count tracks push minus pop.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // State registers; entries are cleared on reset so out_data reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/mul_result_stage.sv
// Result stage behind the unsigned array multiplier: applies signedness
// correction to the high half, selects the half the op wants, and buffers
// the result with its tag in a 2-entry queue toward writeback.
module mul_result_stage
  import mul_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int TAG_W = MUL_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] in_product,
  input  logic [WIDTH-1:0]   in_srca,
  input  logic [WIDTH-1:0]   in_srcb,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] corr_a, corr_b;
  logic [WIDTH-1:0] hi_su, hi_ss;
  logic [WIDTH-1:0] res;

  assign hi = in_product[2*WIDTH-1:WIDTH];
  assign lo = in_product[WIDTH-1:0];

  // A negative operand read as unsigned adds 2^W * (other operand) to the
  // product, so the high half is fixed by subtracting the other operand.
  assign corr_a = in_srca[WIDTH-1] ? in_srcb : '0;
  assign corr_b = in_srcb[WIDTH-1] ? in_srca : '0;
  assign hi_su  = hi - corr_a;
  assign hi_ss  = hi_su - corr_b;

  // Select the stored result by op.
  always_comb begin
    res = lo;
    unique case (in_op)
      MUL_OP_MUL:    res = lo;
      MUL_OP_MULH:   res = hi_ss;
      MUL_OP_MULHSU: res = hi_su;
      MUL_OP_MULHU:  res = hi;
      default:       res = lo;
    endcase
  end

  mul_out_fifo #(
    .DATA_W(WIDTH + TAG_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  ({in_tag, res}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data ({out_tag, out_data})
  );
endmodule

// File: tb/tb_mul_result_stage.sv
// Bench for mul_result_stage at WIDTH=8: directed table, handshake corner
// sequences, and a random phase checked by a queue-based scoreboard.
module tb_mul_result_stage;
  localparam int W  = 8;
  localparam int TW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flush = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] in_product = '0;
  logic [W-1:0]   in_srca = '0, in_srcb = '0;
  logic [1:0]     in_op = '0;
  logic [TW-1:0]  in_tag = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [TW-1:0]  out_tag;

  int nvec = 0;
  int nerr = 0;
  logic [W+TW-1:0] model_q[$];

  always #5 clk = ~clk;

  mul_result_stage #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .in_srca(in_srca), .in_srcb(in_srcb), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  typedef struct {
    logic [W-1:0]  a, b;
    logic [1:0]    op;
    logic [TW-1:0] tag;
    logic [W-1:0]  exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: true signed/unsigned products with integer arithmetic.
  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] a, b, input logic [1:0] op);
    int ua = int'(a), ub = int'(b);
    int sa = int'($signed(a)), sb = int'($signed(b));
    int p;
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = (sa * sb) >>> W;
      2'b10:   p = (sa * ub) >>> W;
      default: p = (ua * ub) >>> W;
    endcase
    return p[W-1:0];
  endfunction

  task automatic drive(input logic [W-1:0] a, b, input logic [1:0] op, input logic [TW-1:0] tag);
    in_srca = a; in_srcb = b; in_op = op; in_tag = tag;
    in_product = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endtask

  // Offer one beat, hold it until accepted, bounded wait.
  task automatic send(input logic [W-1:0] a, b, input logic [1:0] op, input logic [TW-1:0] tag);
    int n = 0;
    drive(a, b, op, tag);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      nvec++; nerr++;
      $display("FAIL send_timeout: in_ready stuck 0, required 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: checks visible state, then applies the cycle's handshakes.
  always @(posedge rst) model_q.delete();
  always @(negedge clk) begin
    if (!rst) begin
      chk("sb_out_valid", 32'(out_valid), 32'(model_q.size() != 0));
      chk("sb_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
      if (out_valid && model_q.size() != 0)
        chk("sb_out_beat", 32'({out_tag, out_data}), 32'(model_q[0]));
      if (flush) model_q.delete();
      else begin
        if (out_valid && out_ready && model_q.size() != 0) void'(model_q.pop_front());
        if (in_valid && in_ready)
          model_q.push_back({in_tag, ref_fn(in_srca, in_srcb, in_op)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [W-1:0] d0;
    logic took;

    vt[0] = '{8'hFF, 8'h02, 2'b00, 5'd1, 8'hFE};
    vt[1] = '{8'hFF, 8'h02, 2'b11, 5'd2, 8'h01};
    vt[2] = '{8'hFF, 8'h02, 2'b10, 5'd3, 8'hFF};
    vt[3] = '{8'hFF, 8'h02, 2'b01, 5'd4, 8'hFF};
    vt[4] = '{8'h80, 8'h80, 2'b01, 5'd5, 8'h40};
    vt[5] = '{8'h80, 8'h80, 2'b10, 5'd6, 8'hC0};
    vt[6] = '{8'h80, 8'h80, 2'b11, 5'd7, 8'h40};
    vt[7] = '{8'h80, 8'h80, 2'b00, 5'd8, 8'h00};

    // Reset state
    #23 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Directed table: one beat per cycle, result visible the next cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].a, vt[i].b, vt[i].op, vt[i].tag);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(vt[i].exp));
      chk($sformatf("tbl%0d_tag", i), 32'(out_tag), 32'(vt[i].tag));
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Backpressure: third beat held off, head stable, then all drain in order
    out_ready = 1'b0;
    fork
      begin
        send(8'h12, 8'h34, 2'b00, 5'd10);
        send(8'hF0, 8'h0F, 2'b01, 5'd11);
        send(8'h85, 8'hC3, 2'b10, 5'd12);
      end
      begin
        repeat (2) @(posedge clk); #1;
        d0 = out_data;
        for (int k = 0; k < 3; k++) begin
          chk("bp_in_ready_low", 32'(in_ready), 0);
          chk("bp_head_stable", 32'(out_data), 32'(d0));
          chk("bp_head_value", 32'(out_data), 32'(ref_fn(8'h12, 8'h34, 2'b00)));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("bp_drained", 32'(out_valid), 0);

    // Steady state at count=1: push and pop every cycle
    out_ready = 1'b0;
    send(8'h01, 8'h01, 2'b00, 5'd20);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [W-1:0] a, b;
      a = 8'($urandom); b = 8'($urandom);
      send(a, b, 2'(k), 5'(k));
      chk("ss_in_ready", 32'(in_ready), 1);
      chk("ss_out_valid", 32'(out_valid), 1);
      chk("ss_out_data", 32'(out_data), 32'(ref_fn(a, b, 2'(k))));
      chk("ss_out_tag", 32'(out_tag), 32'(k));
    end
    repeat (2) @(posedge clk); #1;

    // Flush with two queued and a push offered in the same cycle
    out_ready = 1'b0;
    send(8'h11, 8'h22, 2'b11, 5'd1);
    send(8'h33, 8'h44, 2'b11, 5'd2);
    drive(8'h55, 8'h66, 2'b00, 5'd3);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("flush_push_lost", 32'(out_valid), 0);

    // Async reset mid-stream
    out_ready = 1'b0;
    send(8'hAB, 8'hCD, 2'b00, 5'd9);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_out_tag", 32'(out_tag), 0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(8'h07, 8'h09, 2'b00, 5'd17);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_data", 32'(out_data), 32'(8'h3F));
    chk("post_rst_tag", 32'(out_tag), 17);
    @(posedge clk); #1;

    // Random traffic with occasional flush; scoreboard does the checking
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || took) begin
        drive(8'($urandom), 8'($urandom), 2'($urandom), 5'($urandom));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      if (flush) took = 1'b1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("final_empty", 32'(out_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
